sccb_slave: RTL and testbench
=============================

SCCB_SLAVE -- requirements
Module: sccb_slave

Interface
REQ-001 Parameter DEV_ID, default 7'h3C: 7-bit device ID; write ID byte 0x78, read ID byte 0x79.
REQ-002 clk  input  1  system clock, at least 16x SCL frequency.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 scl_in  input  1  SCCB clock from the bus, asynchronous to clk.
REQ-005 sda_in  input  1  SCCB data from the bus, asynchronous to clk.
REQ-006 sda_oe  output  1  1 = drive SDA low; 0 = release SDA (pull-up).
REQ-007 reg_addr  output  16  register pointer.
REQ-008 reg_wdata  output  8  write data.
REQ-009 reg_we  output  1  one-cycle write strobe.
REQ-010 reg_rdata  input  8  read data for reg_addr.
REQ-011 busy  output  1  high while this device is addressed.

Function
REQ-012 scl_in and sda_in shall each pass a 2-FF synchronizer; all edge detection uses the synchronized values and their previous-cycle copies.
REQ-013 Start condition: SDA falls while SCL is high. Stop condition: SDA rises while SCL is high. Both are detected from any state.
REQ-014 Incoming bits shall be sampled on the synchronized SCL rising edge, MSB first. sda_oe shall change only on the synchronized SCL falling edge, except on start, stop and reset.
REQ-015 States: IDLE, DEVID, DEVID_ACK, ADDR_H, ADDR_H_ACK, ADDR_L, ADDR_L_ACK, WDATA, WDATA_ACK, RDATA, RDATA_NA, IGNORE.
REQ-016 A start condition shall clear the bit counter and go to DEVID, including a repeated start from any state. A stop condition shall go to IDLE and release sda_oe.
REQ-017 DEVID, after 8 bits:
- ID[7:1]==DEV_ID: go to DEVID_ACK.
- Otherwise: go to IGNORE; no ACK is driven and busy stays low.
REQ-018 ACK states: assert sda_oe on the SCL falling edge that ends the 8th bit; release it on the next SCL falling edge, then move to the next state.
REQ-019 Write path (R/W=0): DEVID_ACK -> ADDR_H -> ADDR_H_ACK -> ADDR_L -> ADDR_L_ACK -> WDATA -> WDATA_ACK -> WDATA (repeats).
- reg_addr[15:8] is loaded at the end of ADDR_H.
- reg_addr[7:0] is loaded at the end of ADDR_L.
REQ-020 WDATA: reg_wdata is updated and reg_we pulses high for exactly one clk cycle, in the cycle after the 8th SCL rise is detected.
REQ-021 Read path (R/W=1): DEVID_ACK -> RDATA.
- reg_rdata is loaded into the shift register on the SCL falling edge that ends the ACK bit.
- The slave drives sda_oe = ~bit for 8 bits.
- At the falling edge after bit 8 it releases sda_oe and enters RDATA_NA.
REQ-022 RDATA_NA: SDA sampled low at SCL rise (master ACK) returns to RDATA with the next byte; sampled high (NA) goes to IGNORE.
REQ-023 reg_addr shall persist across transactions, so a 2-phase write followed by a 2-phase read reads the addressed register.
REQ-024 busy shall be high from a DEV_ID match until the next stop, start, or reset.
REQ-025 A partial byte interrupted by start or stop shall be discarded: no reg_we and no reg_addr change.

Reset
REQ-026 rstn low shall immediately force:
- state IDLE
- sda_oe=0, reg_we=0, busy=0
- reg_addr=16'h0000, reg_wdata=8'h00
- synchronizers = 1
- bit counter = 0
REQ-027 Reset mid-transaction shall release SDA within the same cycle. The first start after reset shall be decoded normally.

Configuration
REQ-028 Macro SCCB_SLAVE_AUTOINC_EN:
- Defined: reg_addr increments by 1 (16-bit wrap, 0xFFFF -> 0x0000) one cycle after each reg_we, and after each RDATA byte acknowledged by the master.
- Undefined: reg_addr stays fixed for the whole transaction.

Verification
REQ-029 Write 0x78, 0x30, 0x08, 0x82, stop -> sda_oe low during the 3 ACK bits; one reg_we with reg_addr=0x3008 and reg_wdata=0x82; busy falls at stop.
REQ-030 Write 0x78, 0x30, 0x0A, stop; then 0x79 with reg_rdata=0x56, master NA, stop -> bus bits 0,1,0,1,0,1,1,0; reg_addr=0x300A; no reg_we.
REQ-031 Write 0x42, 0x12, 0x34, 0x56 -> sda_oe never asserted; busy=0; no reg_we.
REQ-032 Write 0x78, 0x10, 0x00, 0xAA, 0xBB:
- SCCB_SLAVE_AUTOINC_EN defined: writes 0xAA@0x1000 and 0xBB@0x1001.
- Undefined: both writes @0x1000.
REQ-033 rstn pulsed low during ADDR_L bit 4 -> sda_oe=0 and busy=0 at once; the following full 0x78, 0x00, 0x01, 0x5A write succeeds.
REQ-034 Repeated start after 5 bits of WDATA, then 0x79 read -> no reg_we; read ACKed; data driven from the retained reg_addr.

Source files
------------

// File: rtl/sccb_slave.sv
// sccb_slave: SCCB/I2C-style register slave with 16-bit register pointer and byte read/write.
// Optional SCCB_SLAVE_AUTOINC_EN: post-increment reg_addr after each write and each master-ACKed read byte.
module sccb_slave #(
   parameter logic [6:0] DEV_ID = 7'h3C
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_oe,
   output logic [15:0] reg_addr,
   output logic [7:0]  reg_wdata,
   output logic        reg_we,
   input  logic [7:0]  reg_rdata,
   output logic        busy
);
   typedef enum logic [3:0] {
      IDLE, DEVID, DEVID_ACK, ADDR_H, ADDR_H_ACK, ADDR_L, ADDR_L_ACK,
      WDATA, WDATA_ACK, RDATA, RDATA_NA, IGNORE
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
   logic        scl_p_q, scl_p_d, sda_p_q, sda_p_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  sh_q, sh_d;
   logic        rw_q, rw_d, oe_q, oe_d, we_q, we_d, busy_q, busy_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        scl_s, sda_s, rise, fall, start, stop, last;

   assign scl_s = scl_sync_q[1];
   assign sda_s = sda_sync_q[1];
   assign rise  = scl_s & ~scl_p_q;
   assign fall  = ~scl_s & scl_p_q;
   assign start = scl_s & scl_p_q & sda_p_q & ~sda_s;
   assign stop  = scl_s & scl_p_q & ~sda_p_q & sda_s;
   assign last  = cnt_q == 4'd7;

   always_comb begin
      scl_sync_d = {scl_sync_q[0], scl_in};
      sda_sync_d = {sda_sync_q[0], sda_in};
      scl_p_d    = scl_s;
      sda_p_d    = sda_s;
      state_d    = state_q;
      cnt_d      = cnt_q;
      sh_d       = sh_q;
      rw_d       = rw_q;
      oe_d       = oe_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = 1'b0;
      busy_d     = busy_q;
`ifdef SCCB_SLAVE_AUTOINC_EN
      if (we_q) addr_d = addr_q + 16'd1;
`endif
      if (start || stop) begin
         state_d = start ? DEVID : IDLE;
         cnt_d   = 4'd0;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else if (rise) begin
         if (state_q inside {DEVID, ADDR_H, ADDR_L, WDATA}) begin
            sh_d  = {sh_q[6:0], sda_s};
            cnt_d = last ? 4'd0 : cnt_q + 4'd1;
         end
         case (state_q)
            DEVID: if (last) begin
               state_d = (sh_d[7:1] == DEV_ID) ? DEVID_ACK : IGNORE;
               busy_d  = sh_d[7:1] == DEV_ID;
               rw_d    = sda_s;
            end
            ADDR_H: if (last) begin
               addr_d[15:8] = sh_d;
               state_d      = ADDR_H_ACK;
            end
            ADDR_L: if (last) begin
               addr_d[7:0] = sh_d;
               state_d     = ADDR_L_ACK;
            end
            WDATA: if (last) begin
               wdata_d = sh_d;
               we_d    = 1'b1;
               state_d = WDATA_ACK;
            end
            RDATA: cnt_d = cnt_q + 4'd1;
            RDATA_NA: if (sda_s) state_d = IGNORE;
            else begin
               cnt_d = 4'd1;
`ifdef SCCB_SLAVE_AUTOINC_EN
               addr_d = addr_q + 16'd1;
`endif
            end
            default: ;
         endcase
      end else if (fall) begin
         case (state_q)
            DEVID_ACK, ADDR_H_ACK, ADDR_L_ACK, WDATA_ACK: if (!oe_q) oe_d = 1'b1;
            else begin
               // ACK just ended: pick the next byte phase
               oe_d    = 1'b0;
               state_d = state_q == ADDR_H_ACK ? ADDR_L : state_q == DEVID_ACK ? ADDR_H : WDATA;
               if (state_q == DEVID_ACK && rw_q) begin
                  sh_d    = reg_rdata;
                  oe_d    = ~reg_rdata[7];
                  cnt_d   = 4'd0;
                  state_d = RDATA;
               end
            end
            RDATA: if (cnt_q == 4'd8) begin
               oe_d    = 1'b0;
               cnt_d   = 4'd0;
               state_d = RDATA_NA;
            end else begin
               oe_d = ~sh_q[6];
               sh_d = {sh_q[6:0], 1'b0};
            end
            RDATA_NA: if (cnt_q != 4'd0) begin
               sh_d    = reg_rdata;
               oe_d    = ~reg_rdata[7];
               cnt_d   = 4'd0;
               state_d = RDATA;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_p_q    <= 1'b1;
         sda_p_q    <= 1'b1;
         cnt_q      <= 4'd0;
         sh_q       <= 8'h00;
         rw_q       <= 1'b0;
         oe_q       <= 1'b0;
         addr_q     <= 16'h0000;
         wdata_q    <= 8'h00;
         we_q       <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_p_q    <= scl_p_d;
         sda_p_q    <= sda_p_d;
         cnt_q      <= cnt_d;
         sh_q       <= sh_d;
         rw_q       <= rw_d;
         oe_q       <= oe_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         busy_q     <= busy_d;
      end
   end

   assign sda_oe    = oe_q;
   assign reg_addr  = addr_q;
   assign reg_wdata = wdata_q;
   assign reg_we    = we_q;
   assign busy      = busy_q;
endmodule

// File: tb/tb_sccb_slave.sv
// tb_sccb_slave: directed SCCB master transactions against sccb_slave with hand-computed expectations.
module tb_sccb_slave;
   localparam int T = 100;
   logic        clk = 1'b0, rstn = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
   logic        sda_oe, reg_we, busy, sda_bus;
   logic [15:0] reg_addr;
   logic [7:0]  reg_wdata, reg_rdata;
   int          total = 0, bad = 0, we_cnt = 0, oe_cnt = 0;
   logic [15:0] we_addr [16];
   logic [7:0]  we_data [16];

   always #5 clk = ~clk;
   assign sda_bus = sda_m & ~sda_oe;
   always_comb reg_rdata = (reg_addr == 16'h300A) ? 8'h56 : (reg_addr[7:0] ^ 8'hC3);

   sccb_slave dut (
      .clk(clk), .rstn(rstn), .scl_in(scl_m), .sda_in(sda_bus), .sda_oe(sda_oe),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
      .reg_rdata(reg_rdata), .busy(busy)
   );

   always @(negedge clk) begin
      if (reg_we) begin
         if (we_cnt < 16) begin
            we_addr[we_cnt] = reg_addr;
            we_data[we_cnt] = reg_wdata;
         end
         we_cnt++;
      end
      if (sda_oe) oe_cnt++;
   end

   task automatic start_c();
      #T sda_m = 1'b1;
      #T scl_m = 1'b1;
      #T sda_m = 1'b0;
      #T scl_m = 1'b0;
   endtask

   task automatic stop_c();
      #T sda_m = 1'b0;
      #T scl_m = 1'b1;
      #T sda_m = 1'b1;
      #(2*T);
   endtask

   task automatic put_bit(input logic b);
      #T sda_m = b;
      #T scl_m = 1'b1;
      #(2*T) scl_m = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) put_bit(b[i]);
      #T sda_m = 1'b1;
      #T scl_m = 1'b1;
      #T ack = ~sda_bus;
      #T scl_m = 1'b0;
   endtask

   task automatic recv_byte(input logic na, output logic [7:0] d);
      for (int i = 7; i >= 0; i--) begin
         #T sda_m = 1'b1;
         #T scl_m = 1'b1;
         #T d[i] = sda_bus;
         #T scl_m = 1'b0;
      end
      put_bit(na);
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      #20;
      total += 5;
      if (sda_oe !== 1'b0) begin bad++; $display("FAIL rst_oe: got %b expected 0", sda_oe); end
      if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
      if (reg_we !== 1'b0) begin bad++; $display("FAIL rst_we: got %b expected 0", reg_we); end
      if (reg_addr !== 16'h0000) begin bad++; $display("FAIL rst_addr: got %h expected 0000", reg_addr); end
      if (reg_wdata !== 8'h00) begin bad++; $display("FAIL rst_wdata: got %h expected 00", reg_wdata); end
      #(T-20) rstn = 1'b1;
      #(2*T);
   endtask

   task automatic test_write();
      logic a0, a1, a2, a3;
      int base = we_cnt;
      start_c();
      send_byte(8'h78, a0);
      send_byte(8'h30, a1);
      send_byte(8'h08, a2);
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy: got %b expected 1", busy); end
      send_byte(8'h82, a3);
      total += 4;
      if ({a0, a1, a2, a3} !== 4'b1111) begin bad++; $display("FAIL wr_acks: got %b expected 1111", {a0, a1, a2, a3}); end
      if (we_cnt - base !== 1) begin bad++; $display("FAIL wr_we_count: got %0d expected 1", we_cnt - base); end
      if (we_addr[base] !== 16'h3008) begin bad++; $display("FAIL wr_addr: got %h expected 3008", we_addr[base]); end
      if (we_data[base] !== 8'h82) begin bad++; $display("FAIL wr_data: got %h expected 82", we_data[base]); end
      stop_c();
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_stop: got %b expected 0", busy); end
   endtask

   task automatic test_read();
      logic a0, a1, a2, a3;
      logic [7:0] d;
      int base = we_cnt;
      start_c();
      send_byte(8'h78, a0);
      send_byte(8'h30, a1);
      send_byte(8'h0A, a2);
      stop_c();
      start_c();
      send_byte(8'h79, a3);
      recv_byte(1'b1, d);
      stop_c();
      total += 4;
      if ({a0, a1, a2, a3} !== 4'b1111) begin bad++; $display("FAIL rd_acks: got %b expected 1111", {a0, a1, a2, a3}); end
      if (d !== 8'h56) begin bad++; $display("FAIL rd_data: got %h expected 56", d); end
      if (reg_addr !== 16'h300A) begin bad++; $display("FAIL rd_addr: got %h expected 300a", reg_addr); end
      if (we_cnt !== base) begin bad++; $display("FAIL rd_no_we: got %0d writes expected 0", we_cnt - base); end
   endtask

   task automatic test_foreign();
      logic a0, a1, a2, a3;
      int base = we_cnt, obase = oe_cnt;
      start_c();
      send_byte(8'h42, a0);
      send_byte(8'h12, a1);
      send_byte(8'h34, a2);
      send_byte(8'h56, a3);
      total += 4;
      if ({a0, a1, a2, a3} !== 4'b0000) begin bad++; $display("FAIL fo_acks: got %b expected 0000", {a0, a1, a2, a3}); end
      if (oe_cnt !== obase) begin bad++; $display("FAIL fo_oe: got %0d driven cycles expected 0", oe_cnt - obase); end
      if (busy !== 1'b0) begin bad++; $display("FAIL fo_busy: got %b expected 0", busy); end
      if (we_cnt !== base) begin bad++; $display("FAIL fo_no_we: got %0d writes expected 0", we_cnt - base); end
      stop_c();
   endtask

   task automatic test_back_to_back();
      logic a0, a1, a2, a3, a4;
      logic [15:0] exp2;
      int base = we_cnt;
`ifdef SCCB_SLAVE_AUTOINC_EN
      exp2 = 16'h1001;
`else
      exp2 = 16'h1000;
`endif
      start_c();
      send_byte(8'h78, a0);
      send_byte(8'h10, a1);
      send_byte(8'h00, a2);
      send_byte(8'hAA, a3);
      send_byte(8'hBB, a4);
      stop_c();
      total += 6;
      if ({a0, a1, a2, a3, a4} !== 5'b11111) begin bad++; $display("FAIL bb_acks: got %b expected 11111", {a0, a1, a2, a3, a4}); end
      if (we_cnt - base !== 2) begin bad++; $display("FAIL bb_we_count: got %0d expected 2", we_cnt - base); end
      if (we_addr[base] !== 16'h1000) begin bad++; $display("FAIL bb_addr0: got %h expected 1000", we_addr[base]); end
      if (we_data[base] !== 8'hAA) begin bad++; $display("FAIL bb_data0: got %h expected aa", we_data[base]); end
      if (we_addr[base+1] !== exp2) begin bad++; $display("FAIL bb_addr1: got %h expected %h", we_addr[base+1], exp2); end
      if (we_data[base+1] !== 8'hBB) begin bad++; $display("FAIL bb_data1: got %h expected bb", we_data[base+1]); end
   endtask

   task automatic test_reset_mid();
      logic a0, a1, a2, a3, a4;
      int base = we_cnt;
      start_c();
      send_byte(8'h78, a0);
      send_byte(8'h77, a1);
      put_bit(1'b1);
      put_bit(1'b0);
      put_bit(1'b1);
      #T sda_m = 1'b0;
      #T scl_m = 1'b1;
      #T;
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL rm_busy_before: got %b expected 1", busy); end
      #1 rstn = 1'b0;
      #1;
      total += 3;
      if (sda_oe !== 1'b0) begin bad++; $display("FAIL rm_oe: got %b expected 0", sda_oe); end
      if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy: got %b expected 0", busy); end
      if (reg_addr !== 16'h0000) begin bad++; $display("FAIL rm_addr: got %h expected 0000", reg_addr); end
      #(T-2) rstn = 1'b1;
      #T scl_m = 1'b0;
      start_c();
      send_byte(8'h78, a2);
      send_byte(8'h00, a3);
      send_byte(8'h01, a4);
      send_byte(8'h5A, a1);
      stop_c();
      total += 4;
      if ({a0, a2, a3, a4, a1} !== 5'b11111) begin bad++; $display("FAIL rm_acks: got %b expected 11111", {a0, a2, a3, a4, a1}); end
      if (we_cnt - base !== 1) begin bad++; $display("FAIL rm_we_count: got %0d expected 1", we_cnt - base); end
      if (we_addr[base] !== 16'h0001) begin bad++; $display("FAIL rm_we_addr: got %h expected 0001", we_addr[base]); end
      if (we_data[base] !== 8'h5A) begin bad++; $display("FAIL rm_we_data: got %h expected 5a", we_data[base]); end
   endtask

   task automatic test_rep_start();
      logic a0, a1, a2, a3;
      logic [7:0] d;
      int base = we_cnt;
      start_c();
      send_byte(8'h78, a0);
      send_byte(8'h12, a1);
      send_byte(8'h34, a2);
      put_bit(1'b1);
      put_bit(1'b0);
      put_bit(1'b1);
      put_bit(1'b1);
      put_bit(1'b0);
      start_c();
      send_byte(8'h79, a3);
      recv_byte(1'b1, d);
      total += 4;
      if ({a0, a1, a2, a3} !== 4'b1111) begin bad++; $display("FAIL rs_acks: got %b expected 1111", {a0, a1, a2, a3}); end
      if (d !== 8'hF7) begin bad++; $display("FAIL rs_data: got %h expected f7", d); end
      if (reg_addr !== 16'h1234) begin bad++; $display("FAIL rs_addr: got %h expected 1234", reg_addr); end
      if (we_cnt !== base) begin bad++; $display("FAIL rs_no_we: got %0d writes expected 0", we_cnt - base); end
      stop_c();
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_foreign();
      test_back_to_back();
      test_reset_mid();
      test_rep_start();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
